uart_rx_cfg: RTL

Parametrised UART receiver and the next-generation replacement for the fixed 8N1 receiver. It supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. Each bit is taken by true 16x-oversampled 3-sample majority voting. Errors are reported per byte, line break is detected, and received bytes are held in a one-entry output register with a ready/valid handshake and overrun reporting. It sits between the board RX pin and the host command decoder.

---
 rtl/uart_rx_cfg.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised 16x-oversampled UART receiver with one-entry holding register
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int M     = OVERSAMPLE / 2;
    localparam int BC_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d, rxs_q, rxs_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [BC_W-1:0]      bit_q, bit_d;
    logic                 samp_a_q, samp_a_d, samp_b_q, samp_b_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d, stop0_q, stop0_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
    logic                 overrun_q, overrun_d, brk_q, brk_d;
    logic                 os_tick, mid_tick, end_tick, maj, par_x, ferr_now, first_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            div_q      <= '0;
            os_q       <= '0;
            bit_q      <= '0;
            samp_a_q   <= 1'b1;
            samp_b_q   <= 1'b1;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop0_q    <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            div_q      <= div_d;
            os_q       <= os_d;
            bit_q      <= bit_d;
            samp_a_q   <= samp_a_d;
            samp_b_q   <= samp_b_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop0_q    <= stop0_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
            brk_q      <= brk_d;
        end
    end

    // Counters only run inside a frame, so their phase is fixed by the start edge.
    assign os_tick  = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH) && (div_q == DIV_W'(DIV - 1));
    assign mid_tick = os_tick && (os_q == OS_W'(M + 1));
    assign end_tick = os_tick && (os_q == OS_W'(OVERSAMPLE - 1));
    assign maj      = (samp_a_q & samp_b_q) | (samp_a_q & rxs_q) | (samp_b_q & rxs_q);

    always_comb begin
        sync1_d    = rx;
        rxs_d      = sync1_q;
        state_d    = state_q;
        div_d      = os_tick ? '0 : div_q + 1'b1;
        os_d       = os_q;
        bit_d      = bit_q;
        samp_a_d   = samp_a_q;
        samp_b_d   = samp_b_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop0_d    = stop0_q;
        data_d     = data_q;
        valid_d    = valid_q && !ready;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
        brk_d      = 1'b0;
        par_x      = (^shift_q) ^ maj;
        ferr_now   = ferr_q | ~maj;
        first_stop = (bit_q == '0) ? maj : stop0_q;
        if (os_tick) begin
            os_d = (os_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_q + 1'b1;
            if (os_q == OS_W'(M - 1)) samp_a_d = rxs_q;
            if (os_q == OS_W'(M))     samp_b_d = rxs_q;
        end
        case (state_q)
            S_IDLE: begin
                div_d     = '0;
                os_d      = '0;
                bit_d     = '0;
                par_bit_d = 1'b0;
                perr_d    = 1'b0;
                ferr_d    = 1'b0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (mid_tick && maj) state_d = S_IDLE;
                else if (end_tick)   state_d = S_DATA;
            end
            S_DATA: begin
                if (mid_tick) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (end_tick) begin
                    if (bit_q == BC_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (mid_tick) begin
                    par_bit_d = maj;
                    perr_d    = (PARITY == 1) ? ~par_x : par_x;
                end
                if (end_tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (mid_tick) begin
                    if (!maj) ferr_d = 1'b1;
                    if (bit_q == '0) stop0_d = maj;
                end
                // The last stop bit closes the frame mid-bit so a back-to-back start is caught.
                if (mid_tick && (bit_q == BC_W'(STOP_BITS - 1))) begin
                    if ((shift_q == '0) && !par_bit_q && !first_stop) begin
                        brk_d   = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end else begin
                        if (!valid_q || ready) begin
                            valid_d    = 1'b1;
                            data_d     = shift_q;
                            perr_out_d = perr_q;
                            ferr_out_d = ferr_now;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
                    end
                end else if (end_tick) begin
                    bit_d = bit_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                div_d = '0;
                os_d  = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data       = data_q;
        valid      = valid_q;
        parity_err = perr_out_q;
        frame_err  = ferr_out_q;
        overrun    = overrun_q;
        break_det  = brk_q;
    end
endmodule
